// File: rtl/issue_ctrl_pkg.sv
// Shared types, constants and instruction-field helpers for the issue controller.
package issue_ctrl_pkg;

  localparam int ISIZE = 32;
  localparam int ASIZE = 5;

  localparam logic [ISIZE-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [5:0]       OP_RTYPE = 6'b000000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  function automatic logic is_rtype(input logic [ISIZE-1:0] ins);
    return ins[31:26] == OP_RTYPE;
  endfunction

  function automatic logic [ASIZE-1:0] dest_reg(input logic [ISIZE-1:0] ins);
    return is_rtype(ins) ? ins[15:11] : ins[20:16];
  endfunction

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic raw_hazard(input logic [ISIZE-1:0] ins,
                                      input logic             ex_valid,
                                      input logic [ASIZE-1:0] ex_waddr);
    logic rs_hit;
    logic rt_hit;
    rs_hit = (ins[25:21] == ex_waddr);
    rt_hit = is_rtype(ins) && (ins[20:16] == ex_waddr);
    return ex_valid && (ex_waddr != 5'd0) && (rs_hit || rt_hit);
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Upstream instruction handshake (valid/ready) between a source and the issue controller.
interface issue_ctrl_if;
  import issue_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ISIZE-1:0] in_inst;

  modport master (output in_valid, output in_inst, input in_ready);
  modport slave  (input in_valid, input in_inst, output in_ready);
endinterface

// File: rtl/issue_ctrl_inst_fifo.sv
// Instruction FIFO; pointers carry an extra wrap bit to tell full from empty.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: buffers instructions, inserts one bubble on a RAW hazard
// against the instruction in EXE, and sequences start/halt with counters.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             halt_i,
  issue_ctrl_if.slave      up,
  output logic [ISIZE-1:0] inst_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] issue_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             halt_pend_q, halt_pend_d;
  logic [ISIZE-1:0] inst_q, inst_d;
  logic             stall_q, stall_d;
  logic             busy_q;
  logic             ex_valid_q;
  logic [ASIZE-1:0] ex_waddr_q;
  logic [CNT_W-1:0] issue_cnt_q, bubble_cnt_q;

  logic [ISIZE-1:0] head_s;
  logic             full_s, empty_s, pop_s, hazard_s;
  logic             issue_s, bubble_s, clear_s;

  assign up.in_ready = ~full_s;

  inst_fifo #(.DEPTH(DEPTH), .WIDTH(ISIZE)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (up.in_valid),
    .pop_i   (pop_s),
    .wdata_i (up.in_inst),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign hazard_s = raw_hazard(head_s, ex_valid_q, ex_waddr_q);

  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    inst_d      = NOP_INST;
    stall_d     = 1'b0;
    pop_s       = 1'b0;
    issue_s     = 1'b0;
    bubble_s    = 1'b0;
    clear_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_RUN;
          clear_s     = 1'b1;
          halt_pend_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN, S_DRAIN: begin
        if (empty_s) begin
          if (state_q == S_DRAIN) state_d = S_IDLE;
          else if (halt_i)        state_d = S_DRAIN;
          else                    state_d = S_RUN;
        end else if (hazard_s) begin
          // Remember a pending drain across the bubble so STALL knows where to return.
          stall_d     = 1'b1;
          bubble_s    = 1'b1;
          state_d     = S_STALL;
          halt_pend_d = halt_i | (state_q == S_DRAIN);
        end else begin
          pop_s   = 1'b1;
          inst_d  = head_s;
          issue_s = 1'b1;
          state_d = halt_i ? S_DRAIN : state_q;
        end
      end
      S_STALL: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          inst_d  = head_s;
          issue_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
        state_d     = (halt_pend_q | halt_i) ? S_DRAIN : S_RUN;
        halt_pend_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      halt_pend_q  <= 1'b0;
      inst_q       <= NOP_INST;
      stall_q      <= 1'b0;
      busy_q       <= 1'b0;
      ex_valid_q   <= 1'b0;
      ex_waddr_q   <= '0;
      issue_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      inst_q      <= inst_d;
      stall_q     <= stall_d;
      busy_q      <= (state_d != S_IDLE);
      ex_valid_q  <= issue_s;
      ex_waddr_q  <= issue_s ? dest_reg(head_s) : '0;
      if (clear_s)                                   issue_cnt_q <= '0;
      else if (issue_s && (issue_cnt_q != CNT_MAX))  issue_cnt_q <= issue_cnt_q + CNT_ONE;
      if (clear_s)                                   bubble_cnt_q <= '0;
      else if (bubble_s && (bubble_cnt_q != CNT_MAX)) bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
    end
  end

  assign inst_o       = inst_q;
  assign stall_o      = stall_q;
  assign busy_o       = busy_q;
  assign issue_cnt_o  = issue_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: a queue-based reference model predicts the
// issued instruction/bubble stream and counters; a monitor compares the DUT output.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic halt_i = 1'b0;
  logic [ISIZE-1:0] inst_o;
  logic busy_o, stall_o;
  logic [CNT_W-1:0] issue_cnt_o, bubble_cnt_o;

  issue_ctrl_if up();

  issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .halt_i       (halt_i),
    .up           (up.slave),
    .inst_o       (inst_o),
    .busy_o       (busy_o),
    .stall_o      (stall_o),
    .issue_cnt_o  (issue_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        stl;
  } ev_t;

  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];
  logic [31:0] mq[$];
  bit running, draining, held;
  int last_dest, m_issue, m_bubble;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int m_dest(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) ? int'(ins[15:11]) : int'(ins[20:16]);
  endfunction

  // Dependency on the instruction issued in the immediately preceding cycle.
  function automatic bit m_hazard(input logic [31:0] ins, input int last);
    int rs;
    int rt;
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    if (last <= 0) return 1'b0;
    return (rs == last) || ((ins[31:26] == 6'd0) && (rt == last));
  endfunction

  function automatic logic [31:0] r_add(input int rd, input int rs, input int rt);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {6'd0, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_addi(input int rt, input int rs, input int imm);
    logic [4:0] s, t;
    logic [15:0] im;
    s = rs[4:0]; t = rt[4:0]; im = imm[15:0];
    return {6'd8, s, t, im};
  endfunction

  task automatic model_cycle();
    bit accept;
    ev_t e;
    logic [31:0] ins;
    check("in_ready", up.in_ready, (mq.size() < DEPTH));
    accept = up.in_valid && (mq.size() < DEPTH);
    if (!running) begin
      if (start_i) begin
        running = 1; draining = 0; m_issue = 0; m_bubble = 0;
      end
      last_dest = -1;
    end else if (mq.size() == 0) begin
      last_dest = -1;
      if (draining) running = 0;
      else if (halt_i) draining = 1;
    end else if (!held && m_hazard(mq[0], last_dest)) begin
      e.ins = 32'h0; e.stl = 1'b1; exp_q.push_back(e);
      m_bubble++; held = 1; last_dest = -1;
      if (halt_i) draining = 1;
    end else begin
      ins = mq.pop_front();
      e.ins = ins; e.stl = 1'b0; exp_q.push_back(e);
      m_issue++; last_dest = m_dest(ins); held = 0;
      if (halt_i) draining = 1;
    end
    if (accept) mq.push_back(up.in_inst);
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    check("busy", busy_o, running);
    check("issue_cnt", issue_cnt_o, m_issue);
    check("bubble_cnt", bubble_cnt_o, m_bubble);
  endtask

  task automatic push(input logic [31:0] ins);
    bit acc;
    up.in_valid = 1'b1;
    up.in_inst  = ins;
    for (int i = 0; i < 50; i++) begin
      acc = up.in_ready;
      tick();
      if (acc) break;
    end
    up.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic drain_to_idle();
    up.in_valid = 1'b0;
    halt_i = 1'b1; tick(); halt_i = 1'b0;
    for (int i = 0; i < 100 && running; i++) tick();
    check("drain_timeout", running, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete(); mq.delete();
    running = 0; draining = 0; held = 0; last_dest = -1; m_issue = 0; m_bubble = 0;
    #1;
    check("rst_inst", inst_o, 32'h0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_issue_cnt", issue_cnt_o, 32'h0);
    check("rst_bubble_cnt", bubble_cnt_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", up.in_ready, 1'b1);
  endtask

  // Monitor: every real instruction or bubble on the output is matched in order.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ((inst_o !== 32'h0) || (stall_o !== 1'b0))) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue: got inst=%h stall=%b expected nothing", inst_o, stall_o);
        end else begin
          e = exp_q.pop_front();
          check("issue_inst", inst_o, e.ins);
          check("issue_stall", stall_o, e.stl);
        end
      end
    end
  end

  initial begin
    logic [31:0] ri;
    up.in_valid = 1'b0;
    up.in_inst  = 32'h0;
    do_reset();

    // Independent instructions go out back to back.
    push(r_add(3, 1, 2)); push(r_add(6, 4, 5));
    pulse_start();
    repeat (4) tick();
    check("nohaz_issue", issue_cnt_o, 32'd2);
    check("nohaz_bubble", bubble_cnt_o, 32'd0);
    drain_to_idle();

    // RAW on rs (R-type) and on rs after an I-type write.
    push(r_add(3, 1, 2)); push(r_add(4, 3, 1)); push(i_addi(3, 1, 5)); push(i_addi(7, 3, 1));
    pulse_start();
    repeat (8) tick();
    check("raw_issue", issue_cnt_o, 32'd4);
    check("raw_bubble", bubble_cnt_o, 32'd2);
    drain_to_idle();

    // r0 destinations and I-type rt-as-destination never stall.
    push(r_add(0, 1, 2)); push(r_add(4, 0, 0)); push(i_addi(5, 1, 1)); push(i_addi(5, 2, 2));
    pulse_start();
    repeat (6) tick();
    check("r0_issue", issue_cnt_o, 32'd4);
    check("r0_bubble", bubble_cnt_o, 32'd0);
    drain_to_idle();

    // Full FIFO: fifth instruction held until issue frees a slot.
    for (int i = 0; i < 4; i++) push(r_add(10 + i, 20, 21));
    up.in_valid = 1'b1; up.in_inst = r_add(15, 22, 23);
    tick();
    check("full_ready", up.in_ready, 1'b0);
    start_i = 1'b1; tick(); start_i = 1'b0;
    push(r_add(15, 22, 23));
    repeat (6) tick();
    check("full_issue", issue_cnt_o, 32'd5);
    drain_to_idle();

    // Halt with two queued; a start in the final drain cycle is ignored.
    push(r_add(3, 1, 2)); push(r_add(6, 4, 5));
    pulse_start();
    halt_i = 1'b1; tick(); halt_i = 1'b0;
    for (int i = 0; i < 20 && running; i++) begin
      start_i = (draining && mq.size() == 0) ? 1'b1 : 1'b0;
      tick();
      start_i = 1'b0;
    end
    check("halt_busy_idle", busy_o, 1'b0);
    check("halt_issue", issue_cnt_o, 32'd2);
    pulse_start();
    check("restart_busy", busy_o, 1'b1);
    drain_to_idle();

    // Reset mid-run with three entries still queued.
    for (int i = 0; i < 4; i++) push(r_add(10 + i, 20, 21));
    pulse_start();
    tick();
    do_reset();
    pulse_start();
    repeat (5) tick();
    check("post_rst_issue", issue_cnt_o, 32'd0);
    drain_to_idle();

    // Randomized traffic with occasional start/halt pulses.
    for (int c = 0; c < 1500; c++) begin
      ri = {($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'd0, 6'h20};
      up.in_valid = ($urandom_range(0, 2) != 0);
      up.in_inst  = ri;
      start_i     = ($urandom_range(0, 19) == 0);
      halt_i      = ($urandom_range(0, 29) == 0);
      tick();
    end
    start_i = 1'b0; halt_i = 1'b0;
    drain_to_idle();
    tick();
    @(negedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
